// File: rtl/rom_loader.sv
// rom_loader: streams host-download bytes into the SDRAM ROM area.
// System-ROM blocks are remapped to fixed pages. Expansion ROMs land on a
// page chosen from the file extension. Each byte can be replicated across
// all memory banks, and every loaded high page is flagged in rom_map.
module rom_loader #(
  parameter int NUM_BANKS = 2,
  parameter int PAGE_BITS = 8,
  parameter bit CLEAR_MAP = 1'b1,
  localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int AW       = PAGE_BITS + 15,
  localparam int MAPW     = 1 << PAGE_BITS
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            ce_ref,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  input  logic [7:0]      ioctl_index,
  input  logic [15:0]     ioctl_file_ext,
  output logic            ioctl_wait,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [BW-1:0]   mem_bank,
  output logic [7:0]      mem_dout,
  output logic [MAPW-1:0] rom_map
);

  localparam logic [BW-1:0] LAST_BANK  = BW'(NUM_BANKS - 1);
  localparam int            SYS_BLOCKS = 4 * NUM_BANKS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WRITE,
    S_GAP
  } state_t;

  // Returns {valid, value} for an upper-case ASCII hex digit.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  // Fixed page for each 16 KB system-ROM block within a bank.
  function automatic logic [PAGE_BITS:0] sys_page(input logic [1:0] blk);
    logic [PAGE_BITS:0] r;
    case (blk)
      2'd0:    r = '0;
      2'd1:    r = {1'b1, PAGE_BITS'(8'h00)};
      2'd2:    r = {1'b1, PAGE_BITS'(8'h07)};
      default: r = {1'b1, PAGE_BITS'(8'hFF)};
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic               dl_q, dl_d;
  logic [PAGE_BITS:0] page_q, page_d;
  logic               combo_q, combo_d;
  logic               rep_q, rep_d;
  logic               wait_q, wait_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BW-1:0]      bank_q, bank_d;
  logic [7:0]         dout_q, dout_d;
  logic [MAPW-1:0]    map_q, map_d;

  logic               dl_rise;
  logic               index_nz;
  logic               replicate;
  logic [4:0]         hex_hi, hex_lo;
  logic [PAGE_BITS:0] parse_page;
  logic               parse_combo;
  logic [7:0]         parse_pg8;
  logic               parse_flag;
  logic [10:0]        sys_k;
  logic               sys_drop;
  logic [BW-1:0]      sys_bank;
  logic [PAGE_BITS:0] ext_upper;
  logic [BW-1:0]      ext_bank;

  assign dl_rise   = ioctl_download & ~dl_q;
  assign index_nz  = (ioctl_index != 8'd0);
  assign replicate = index_nz && ((ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0));
  assign hex_hi    = hex_nibble(ioctl_file_ext[15:8]);
  assign hex_lo    = hex_nibble(ioctl_file_ext[7:0]);

  assign sys_k     = ioctl_addr[24:14];
  assign sys_drop  = (int'({21'd0, sys_k}) >= SYS_BLOCKS);
  assign sys_bank  = BW'(sys_k >> 2);

  // Expansion pages advance with the 16 KB block number and wrap within the field.
  assign ext_upper = {page_q[PAGE_BITS], page_q[PAGE_BITS-1:0] + PAGE_BITS'(ioctl_addr[21:14])};
  assign ext_bank  = replicate ? '0 : BW'(&ioctl_index[7:6]);

  // Decode the file extension into a start page and the combo-cartridge flag.
  always_comb begin
    parse_pg8   = 8'hEE;
    parse_flag  = 1'b1;
    parse_combo = 1'b0;
    if (hex_hi[4]) begin
      parse_pg8[7:4] = hex_hi[3:0];
      parse_flag     = 1'b0;
    end
    if (hex_lo[4]) begin
      parse_pg8[3:0] = hex_lo[3:0];
      parse_flag     = 1'b0;
    end
    if (ioctl_file_ext == 16'h5A5A) begin
      parse_pg8  = 8'h00;
      parse_flag = 1'b0;
    end else if (ioctl_file_ext == 16'h5A30) begin
      parse_pg8   = 8'h00;
      parse_flag  = 1'b0;
      parse_combo = 1'b1;
    end
    parse_page = {parse_flag, PAGE_BITS'(parse_pg8)};
  end

  // Byte-write sequencer: accept, then one mem_wr ce_ref period per bank.
  always_comb begin
    state_d = state_q;
    dl_d    = ioctl_download;
    page_d  = page_q;
    combo_d = combo_q;
    rep_d   = rep_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    dout_d  = dout_q;
    map_d   = map_q;

    case (state_q)
      S_IDLE: begin
        if (ioctl_wr && ioctl_download) begin
          dout_d        = ioctl_dout;
          addr_d[13:0]  = ioctl_addr[13:0];
          if (index_nz) begin
            addr_d[AW-1:14] = ext_upper;
            bank_d          = ext_bank;
            rep_d           = replicate;
            wait_d          = 1'b1;
            state_d         = S_ARM;
          end else begin
            addr_d[AW-1:14] = sys_page(sys_k[1:0]);
            bank_d          = sys_bank;
            rep_d           = 1'b0;
            if (!sys_drop) begin
              wait_d  = 1'b1;
              state_d = S_ARM;
            end
          end
        end
      end
      S_ARM: begin
        if (ce_ref) begin
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ce_ref) begin
          wr_d    = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (rep_q && (bank_q < LAST_BANK)) begin
          bank_d  = bank_q + BW'(1);
          state_d = S_ARM;
        end else begin
          wait_d = 1'b0;
          if (addr_q[AW-1]) begin
            map_d[addr_q[AW-2:14]] = 1'b1;
          end
          // The combo cartridge switches to the MF2 page after its first 16 KB.
          if (combo_q && (addr_q[13:0] == 14'h3FFF)) begin
            page_d  = '1;
            combo_d = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (dl_rise) begin
      if (index_nz) begin
        page_d  = parse_page;
        combo_d = parse_combo;
      end else if (CLEAR_MAP) begin
        map_d = '0;
      end
    end
  end

  // State and output registers; reset clears everything, including a live mem_wr.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      page_q  <= '0;
      combo_q <= 1'b0;
      rep_q   <= 1'b0;
      wait_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      bank_q  <= '0;
      dout_q  <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      page_q  <= page_d;
      combo_q <= combo_d;
      rep_q   <= rep_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      dout_q  <= dout_d;
      map_q   <= map_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_bank   = bank_q;
  assign mem_dout   = dout_q;
  assign rom_map    = map_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader (NUM_BANKS=2, PAGE_BITS=8, CLEAR_MAP=1).
module tb_rom_loader;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic         ce_ref = 1'b0;
  logic         ioctl_download = 1'b0;
  logic         ioctl_wr = 1'b0;
  logic [24:0]  ioctl_addr = '0;
  logic [7:0]   ioctl_dout = '0;
  logic [7:0]   ioctl_index = '0;
  logic [15:0]  ioctl_file_ext = '0;
  logic         ioctl_wait;
  logic         mem_wr;
  logic [22:0]  mem_addr;
  logic [0:0]   mem_bank;
  logic [7:0]   mem_dout;
  logic [255:0] rom_map;

  rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_file_ext (ioctl_file_ext),
    .ioctl_wait     (ioctl_wait),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_bank       (mem_bank),
    .mem_dout       (mem_dout),
    .rom_map        (rom_map)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // ce_ref: one clk_sys cycle high out of every four.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk_sys);
      cnt    = (cnt + 1) % 4;
      ce_ref = (cnt == 0);
    end
  end

  int           n_cmp = 0;
  int           n_err = 0;
  int           pulses;
  int           wr_cycles;
  logic         saw_wait;
  logic         timed_out;
  logic [22:0]  p_addr [4];
  logic [0:0]   p_bank [4];
  logic [7:0]   p_dout;
  logic [255:0] exp_map;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one byte and follow it until ioctl_wait drops, recording each mem_wr pulse.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    logic prev;
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    saw_wait   = ioctl_wait;
    pulses     = 0;
    wr_cycles  = 0;
    timed_out  = 1'b1;
    prev       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_wr && !prev) begin
        if (pulses < 4) begin
          p_addr[pulses] = mem_addr;
          p_bank[pulses] = mem_bank;
        end
        p_dout = mem_dout;
        pulses++;
      end
      if (mem_wr) wr_cycles++;
      prev = mem_wr;
      if (!ioctl_wait && !mem_wr) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic start_download(input logic [7:0] idx, input logic [15:0] ext);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_file_ext = ext;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk_sys);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_wr",   mem_wr,     1'b0);
    check("rst_addr", mem_addr,   23'h0);
    check("rst_bank", mem_bank,   1'b0);
    check("rst_dout", mem_dout,   8'h00);
    check("rst_map",  rom_map,    256'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // System ROM: block 1 -> page 0x100, bank 0
    start_download(8'h00, 16'h2020);
    send_byte(25'h0004123, 8'h3C);
    check("sys1_wait",   saw_wait,  1'b1);
    check("sys1_pulses", pulses,    1);
    check("sys1_addr",   p_addr[0], 23'h400123);
    check("sys1_bank",   p_bank[0], 1'b0);
    check("sys1_dout",   p_dout,    8'h3C);
    check("sys1_wrlen",  wr_cycles, 4);
    check("sys1_done",   timed_out, 1'b0);
    check("sys1_waitlo", ioctl_wait, 1'b0);
    exp_map = '0;
    exp_map[8'h00] = 1'b1;
    check("sys1_map", rom_map, exp_map);

    // Block 8 is past the last bank: dropped silently
    send_byte(25'h0020000, 8'h55);
    check("drop_wait",   saw_wait, 1'b0);
    check("drop_pulses", pulses,   0);

    // Block 2 -> page 0x107, bank 0
    send_byte(25'h0008010, 8'h5A);
    check("sys2_addr", p_addr[0], 23'h41C010);
    check("sys2_bank", p_bank[0], 1'b0);
    exp_map[8'h07] = 1'b1;
    check("sys2_map", rom_map, exp_map);

    // Block 7 -> page 0x1FF, bank 1
    send_byte(25'h001C005, 8'hC3);
    check("sys7_addr", p_addr[0], 23'h7FC005);
    check("sys7_bank", p_bank[0], 1'b1);
    exp_map[8'hFF] = 1'b1;
    check("sys7_map", rom_map, exp_map);

    // Expansion "07", index 0x41 replicates to both banks; page 0x07+1
    start_download(8'h41, 16'h3037);
    send_byte(25'h0004000, 8'hA5);
    check("rep_wait",   saw_wait,  1'b1);
    check("rep_pulses", pulses,    2);
    check("rep_addr0",  p_addr[0], 23'h020000);
    check("rep_bank0",  p_bank[0], 1'b0);
    check("rep_addr1",  p_addr[1], 23'h020000);
    check("rep_bank1",  p_bank[1], 1'b1);
    check("rep_dout",   p_dout,    8'hA5);
    check("rep_wrlen",  wr_cycles, 8);
    check("rep_map",    rom_map,   exp_map);

    // Expansion "FF" plus block 2 wraps to page 0x01
    start_download(8'h41, 16'h4646);
    send_byte(25'h0008000, 8'h01);
    check("wrap_pulses", pulses,    2);
    check("wrap_addr",   p_addr[0], 23'h004000);

    // Combo "Z0", index 0x80 (single bank 0): page 0, then MF2 page after 0x3FFF
    start_download(8'h80, 16'h5A30);
    send_byte(25'h0003FFE, 8'h11);
    check("combo_a_addr", p_addr[0], 23'h003FFE);
    check("combo_a_bank", p_bank[0], 1'b0);
    check("combo_a_puls", pulses,    1);
    send_byte(25'h0003FFF, 8'h22);
    check("combo_b_addr", p_addr[0], 23'h003FFF);
    send_byte(25'h0000010, 8'h33);
    check("combo_c_addr", p_addr[0], 23'h7FC010);
    check("combo_map",    rom_map,   exp_map);

    // Non-hex "QQ", index 0xC0: default page 0x1EE, bank 1
    start_download(8'hC0, 16'h5151);
    send_byte(25'h0000000, 8'h77);
    check("qq_pulses", pulses,    1);
    check("qq_addr",   p_addr[0], 23'h7B8000);
    check("qq_bank",   p_bank[0], 1'b1);
    exp_map[8'hEE] = 1'b1;
    check("qq_map", rom_map, exp_map);

    // Reset asserted while mem_wr is high
    start_download(8'h80, 16'h3132);
    @(negedge clk_sys);
    ioctl_addr = 25'h0000100;
    ioctl_dout = 8'h99;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    seen       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_wr) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("mid_wr_seen", seen, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr",   mem_wr,     1'b0);
    check("mid_rst_wait", ioctl_wait, 1'b0);
    check("mid_rst_map",  rom_map,    256'h0);
    check("mid_rst_addr", mem_addr,   23'h0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;

    // Fresh download after reset starts from IDLE
    start_download(8'h00, 16'h2020);
    send_byte(25'h0004000, 8'h42);
    check("post_pulses", pulses,    1);
    check("post_addr",   p_addr[0], 23'h400000);
    check("post_dout",   p_dout,    8'h42);
    exp_map = '0;
    exp_map[8'h00] = 1'b1;
    check("post_map", rom_map, exp_map);

    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
